motion_reg_arbiter: RTL

// Shares the single AXI4-Lite slave port of the MotionController register bank between two requesters:
// req 0 = safety/obstacle path (high priority), req 1 = navigation path.

---
 rtl/motion_ctrl_pkg.sv | 26 ++
 rtl/motion_grant_sel.sv | 49 ++++
 rtl/motion_reg_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/motion_ctrl_pkg.sv
// Shared types and constants for the MotionController register-bank arbiter.
//   arb_state_t   : transaction FSM states
//   AXI_RESP_OKAY : AXI4-Lite OKAY response code
//   REG_*         : byte offsets of the motion registers
package motion_ctrl_pkg;

   localparam int unsigned AXI_RESP_W = 2;
   localparam int unsigned REG_OFF_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WRESP,
      RD,
      RRESP,
      DONE
   } arb_state_t;

   localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

   localparam logic [REG_OFF_W-1:0] REG_CMD    = 4'h0;
   localparam logic [REG_OFF_W-1:0] REG_SPEED  = 4'h4;
   localparam logic [REG_OFF_W-1:0] REG_STEER  = 4'h8;
   localparam logic [REG_OFF_W-1:0] REG_STATUS = 4'hC;

endpackage

// File: rtl/motion_grant_sel.sv
// Two-requester priority select with starvation protection for requester 1.
//   clk, rst_n    : clock, async active-low reset
//   req_valid     : pending requests (bit 0 = safety path, bit 1 = navigation path)
//   grant_en      : arbiter is able to accept a grant this cycle
//   grant_idx_c   : selected requester (combinational)
//   grant_vld_c   : some requester is selected (combinational)
module motion_grant_sel #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic       grant_en,
   output logic       grant_idx_c,
   output logic       grant_vld_c
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;

   assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

   // Requester 0 wins unless requester 1 has waited through STARVE_MAX grants
   always_comb begin
      grant_vld_c = |req_valid;
      grant_idx_c = 1'b0;
      if (req_valid[1] && (!req_valid[0] || starved)) begin
         grant_idx_c = 1'b1;
      end
   end

   // Counts requester-0 grants taken while requester 1 is waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!req_valid[1]) begin
         starve_cnt <= '0;
      end else if (grant_en && grant_vld_c) begin
         if (grant_idx_c) begin
            starve_cnt <= '0;
         end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/motion_reg_arbiter.sv
// Serializes single-beat register requests from two requesters onto one AXI4-Lite master port.
//   ACLK, ARESETN            : clock, async active-low reset
//   req_valid/write/addr/wdata[i] : request i, held until its ack
//   req_ack/rdata/err[i]     : completion pulse, read data (held), error flag
//   m_axi_*                  : AXI4-Lite master (AW, W, B, AR, R channels)
module motion_reg_arbiter
   import motion_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_write,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][DATA_W-1:0] req_wdata,
   output logic [1:0]             req_ack,
   output logic [1:0][DATA_W-1:0] req_rdata,
   output logic [1:0]             req_err,
   output logic [ADDR_W-1:0]      m_axi_awaddr,
   output logic [2:0]             m_axi_awprot,
   output logic                   m_axi_awvalid,
   input  logic                   m_axi_awready,
   output logic [DATA_W-1:0]      m_axi_wdata,
   output logic [DATA_W/8-1:0]    m_axi_wstrb,
   output logic                   m_axi_wvalid,
   input  logic                   m_axi_wready,
   input  logic [1:0]             m_axi_bresp,
   input  logic                   m_axi_bvalid,
   output logic                   m_axi_bready,
   output logic [ADDR_W-1:0]      m_axi_araddr,
   output logic [2:0]             m_axi_arprot,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,
   input  logic [DATA_W-1:0]      m_axi_rdata,
   input  logic [1:0]             m_axi_rresp,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready
);

   arb_state_t        state, state_nxt;
   logic              gnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              grant_idx_c, grant_vld_c;
   logic              aw_done, w_done;

   motion_grant_sel #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant_sel (
      .clk         (ACLK),
      .rst_n       (ARESETN),
      .req_valid   (req_valid),
      .grant_en    (state == IDLE),
      .grant_idx_c (grant_idx_c),
      .grant_vld_c (grant_vld_c)
   );

   // A write channel is finished once its VALID has dropped or is handshaking now
   assign aw_done = !m_axi_awvalid || m_axi_awready;
   assign w_done  = !m_axi_wvalid  || m_axi_wready;

   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_awprot = '0;
   assign m_axi_arprot = '0;
   assign m_axi_wstrb  = '1;

   // State register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld_c) state_nxt = req_write[grant_idx_c] ? WR : RD;
         WR:      if (aw_done && w_done) state_nxt = WRESP;
         WRESP:   if (m_axi_bvalid) state_nxt = DONE;
         RD:      if (m_axi_arready) state_nxt = RRESP;
         RRESP:   if (m_axi_rvalid) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered AXI handshakes, request capture and completion reporting
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         gnt_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         req_ack       <= '0;
         req_err       <= '0;
         req_rdata     <= '0;
      end else begin
         req_ack <= '0;
         req_err <= '0;
         case (state)
            IDLE: begin
               if (grant_vld_c) begin
                  gnt_q   <= grant_idx_c;
                  addr_q  <= req_addr[grant_idx_c];
                  wdata_q <= req_wdata[grant_idx_c];
                  if (req_write[grant_idx_c]) begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                  end
               end
            end
            WR: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
               if (aw_done && w_done) m_axi_bready <= 1'b1;
            end
            WRESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready   <= 1'b0;
                  req_ack[gnt_q] <= 1'b1;
                  req_err[gnt_q] <= (m_axi_bresp != AXI_RESP_OKAY);
               end
            end
            RD: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
               end
            end
            RRESP: begin
               if (m_axi_rvalid) begin
                  m_axi_rready     <= 1'b0;
                  req_ack[gnt_q]   <= 1'b1;
                  req_err[gnt_q]   <= (m_axi_rresp != AXI_RESP_OKAY);
                  req_rdata[gnt_q] <= m_axi_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
